tile_raster_writer: RTL and testbench

- Sink end of the denoise datapath: accepts 3x12 output tiles (tile_valid/tile_data) from the filter core and reassembles them into a raster stream for the frame writer.
- Tiles arrive band by band: 53 tiles per band, left to right, 3 output rows per band, 160 bands per 636x480 output frame.
- Ping-pong band buffer: one bank fills while the other drains as 12-pixel raster beats with valid/ready.

---
 rtl/tile_raster_pkg.sv | 35 +++
 rtl/tile_raster_writer_band_bank.sv | 27 ++
 rtl/tile_raster_writer.sv | 163 ++++++++++++++++
 tb/tb_tile_raster_writer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_raster_pkg.sv
// Shared geometry, counter widths and read-FSM states for the tile raster writer.
package tile_raster_pkg;

    localparam int PIX_W  = 8;
    localparam int TILE_W = 12;
    localparam int TILE_H = 3;
    localparam int OUT_W  = 636;
    localparam int OUT_H  = 480;

    localparam int TILES_PER_BAND = OUT_W / TILE_W;
    localparam int BANDS          = OUT_H / TILE_H;

    localparam int WORD_W    = PIX_W * TILE_W;
    localparam int TILE_BITS = WORD_W * TILE_H;

    localparam int TIDX_W = $clog2(TILES_PER_BAND);
    localparam int BAND_W = $clog2(BANDS);
    localparam int TROW_W = $clog2(TILE_H);
    localparam int ROW_W  = $clog2(OUT_H);
    localparam int COL_W  = $clog2(OUT_W);

    typedef enum logic [1:0] {IDLE, LOAD, SEND} rd_state_t;

    // Frame row of tile row r inside a band.
    function automatic logic [ROW_W-1:0] raster_row(input logic [BAND_W-1:0] band,
                                                    input logic [TROW_W-1:0] r);
        return ROW_W'(band) * ROW_W'(TILE_H) + ROW_W'(r);
    endfunction

    // First frame column covered by beat t.
    function automatic logic [COL_W-1:0] raster_col(input logic [TIDX_W-1:0] t);
        return COL_W'(t) * COL_W'(TILE_W);
    endfunction

endpackage

// File: rtl/tile_raster_writer_band_bank.sv
// One band buffer: TILE_H rows x TILES_PER_BAND words. A whole tile (all rows)
// is written per cycle; one word is read combinationally.
module band_bank
    import tile_raster_pkg::*;
(
    input  logic                 clk,
    input  logic                 we,
    input  logic [TIDX_W-1:0]    wr_col,
    input  logic [TILE_BITS-1:0] wr_data,
    input  logic [TROW_W-1:0]    rd_row,
    input  logic [TIDX_W-1:0]    rd_col,
    output logic [WORD_W-1:0]    rd_data
);

    logic [WORD_W-1:0] mem [TILE_H][TILES_PER_BAND];

    // Scatter the tile rows into their band rows; row 0 sits in the tile MSBs.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int r = 0; r < TILE_H; r++)
                mem[r][wr_col] <= wr_data[(TILE_H-1-r)*WORD_W +: WORD_W];
        end
    end

    assign rd_data = mem[rd_row][rd_col];

endmodule

// File: rtl/tile_raster_writer.sv
// Tile-to-raster reassembly with a ping-pong band buffer.
// Optional: define TILE_OVERRUN_DET_EN to get a sticky overrun flag for tiles
// offered while both banks are full (the filter core cannot be stalled).
module tile_raster_writer
    import tile_raster_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 tile_valid,
    output logic                                 tile_ready,
    input  logic [PIX_W*TILE_W*TILE_H-1:0]       tile_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PIX_W*TILE_W-1:0]              out_data,
    output logic [8:0]                           out_row,
    output logic [9:0]                           out_col,
    output logic                                 out_eol,
    output logic                                 frame_done,
    output logic                                 overrun
);

    logic [1:0]              full, full_set, full_clr;
    logic                    wr_bank, rd_bank;
    logic [TIDX_W-1:0]       tile_idx, beat, beat_nxt, rd_col;
    logic [TROW_W-1:0]       row, row_nxt, rd_row;
    logic [BAND_W-1:0]       band_in, band_out;
    logic [1:0][WORD_W-1:0]  bank_rd;
    logic                    tile_acc, last_tile, beat_acc, eor, last_beat;
    rd_state_t               state, state_nxt;

    assign tile_ready = !full[wr_bank];
    assign tile_acc   = tile_valid && tile_ready;
    assign last_tile  = tile_idx == TIDX_W'(TILES_PER_BAND-1);
    assign beat_acc   = (state == SEND) && out_valid && out_ready;
    assign eor        = beat == TIDX_W'(TILES_PER_BAND-1);
    assign last_beat  = beat_acc && eor && (row == TROW_W'(TILE_H-1));

    // Flags are set by the writer and cleared by the reader; they never hit the same bank.
    assign full_set = (tile_acc && last_tile) ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = last_beat ? (2'b01 << rd_bank) : 2'b00;

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            band_bank u_bank (
                .clk     (clk),
                .we      (tile_acc && (wr_bank == 1'(b))),
                .wr_col  (tile_idx),
                .wr_data (tile_data),
                .rd_row  (rd_row),
                .rd_col  (rd_col),
                .rd_data (bank_rd[b])
            );
        end
    endgenerate

    // Write side: tile position within the band, band count and fill bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_idx <= '0;
            band_in  <= '0;
            wr_bank  <= 1'b0;
        end else if (tile_acc) begin
            if (last_tile) begin
                tile_idx <= '0;
                wr_bank  <= ~wr_bank;
                band_in  <= (band_in == BAND_W'(BANDS-1)) ? '0 : band_in + 1'b1;
            end else begin
                tile_idx <= tile_idx + 1'b1;
            end
        end
    end

    // Bank full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) full <= 2'b00;
        else        full <= (full | full_set) & ~full_clr;
    end

    // Next beat position and the read address feeding the output register.
    always_comb begin
        beat_nxt = eor ? '0 : beat + 1'b1;
        row_nxt  = row;
        if (eor) row_nxt = (row == TROW_W'(TILE_H-1)) ? '0 : row + 1'b1;
        rd_row = '0;
        rd_col = '0;
        if (state == SEND) begin
            rd_row = row_nxt;
            rd_col = beat_nxt;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Read FSM next state; the other bank is checked with its pre-edge flag.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (full[rd_bank]) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (last_beat) state_nxt = full[~rd_bank] ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output beat register: loads on LOAD and on every accepted beat, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_bank    <= 1'b0;
            band_out   <= '0;
            beat       <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_eol    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == LOAD) begin
                out_valid <= 1'b1;
                out_data  <= bank_rd[rd_bank];
                beat      <= '0;
                row       <= '0;
                out_row   <= raster_row(band_out, TROW_W'(0));
                out_col   <= '0;
                out_eol   <= 1'b0;
            end else if (beat_acc) begin
                if (last_beat) begin
                    out_valid  <= 1'b0;
                    rd_bank    <= ~rd_bank;
                    beat       <= '0;
                    row        <= '0;
                    frame_done <= band_out == BAND_W'(BANDS-1);
                    band_out   <= (band_out == BAND_W'(BANDS-1)) ? '0 : band_out + 1'b1;
                end else begin
                    beat     <= beat_nxt;
                    row      <= row_nxt;
                    out_data <= bank_rd[rd_bank];
                    out_row  <= raster_row(band_out, row_nxt);
                    out_col  <= raster_col(beat_nxt);
                    out_eol  <= beat_nxt == TIDX_W'(TILES_PER_BAND-1);
                end
            end
        end
    end

`ifdef TILE_OVERRUN_DET_EN
    // Sticky: any tile offered while both banks are full is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        overrun <= 1'b0;
        else if (tile_valid && !tile_ready) overrun <= 1'b1;
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_tile_raster_writer.sv
// Bench for tile_raster_writer: band-image scoreboard plus directed literal checks.
module tb_tile_raster_writer;

    localparam int PW = 8, TW = 12, TH = 3, OW = 636, OH = 480;
    localparam int TPB = OW / TW, NB = OH / TH;
    localparam int WW = PW * TW, TBITS = WW * TH;
`ifdef TILE_OVERRUN_DET_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    logic            clk = 0, rst_n = 0, tile_valid = 0, out_ready = 0;
    logic [TBITS-1:0] tile_data = '0;
    logic            tile_ready, out_valid, out_eol, frame_done, overrun;
    logic [WW-1:0]   out_data;
    logic [8:0]      out_row;
    logic [9:0]      out_col;

    tile_raster_writer dut (
        .clk(clk), .rst_n(rst_n), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .tile_data(tile_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_eol(out_eol),
        .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Stimulus pixel: tile g, row r, column c.
    function automatic logic [TBITS-1:0] mk_tile(input int g);
        logic [TBITS-1:0] t;
        t = '0;
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++)
                t[(TH-1-r)*WW + (TW-1-c)*PW +: PW] = 8'((g*TW + c + r*7) & 255);
        return t;
    endfunction

    // Model: a band image filled by accepted tiles; a full band becomes 159 raster beats.
    typedef struct {
        logic [8:0]    row;
        logic [9:0]    col;
        logic [WW-1:0] data;
        logic          eol;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] img [TH][OW];
    int         m_tidx = 0, m_band = 0;

    task automatic model_accept(input logic [TBITS-1:0] td);
        beat_t e;
        for (int r = 0; r < TH; r++)
            for (int c = 0; c < TW; c++)
                img[r][m_tidx*TW + c] = td[(TH-1-r)*WW + (TW-1-c)*PW +: PW];
        m_tidx++;
        if (m_tidx == TPB) begin
            for (int r = 0; r < TH; r++)
                for (int bt = 0; bt < TPB; bt++) begin
                    e.row = 9'(m_band*TH + r);
                    e.col = 10'(bt*TW);
                    e.eol = (bt == TPB-1);
                    for (int c = 0; c < TW; c++)
                        e.data[(TW-1-c)*PW +: PW] = img[r][bt*TW + c];
                    exp_q.push_back(e);
                end
            m_tidx = 0;
            m_band = (m_band + 1) % NB;
        end
    endtask

    // Observation stats for directed checks.
    int            n_beats = 0, n_fd = 0, beats_at_fd = 0;
    int            eol_q[$];
    bit            got_first = 0, got_after = 0;
    logic [WW-1:0] first_data;
    logic [8:0]    first_row, after_row;
    logic [9:0]    first_col, after_col;
    logic [7:0]    pix624 = 0;
    bit            exp_fd = 0, p_stall = 0, tog = 0;
    logic [WW-1:0] p_data;
    logic [8:0]    p_row;
    logic [9:0]    p_col;
    logic          p_eol;

    task automatic clr_stats();
        n_beats = 0; n_fd = 0; beats_at_fd = 0; eol_q.delete();
        got_first = 0; got_after = 0; pix624 = 0;
    endtask

    // Compare process: all handshakes complete at the next rising edge.
    always @(negedge clk) begin : mon
        beat_t e;
        if (!rst_n) begin
            exp_q.delete(); m_tidx = 0; m_band = 0; exp_fd = 0; p_stall = 0;
            chk("reset out_valid", out_valid, 0);
            chk("reset tile_ready", tile_ready, 1);
        end else begin
            chk("frame_done", frame_done, exp_fd);
            exp_fd = 0;
            if (p_stall) begin
                chk("hold out_valid", out_valid, 1);
                chk("hold out_data", out_data, p_data);
                chk("hold out_row", out_row, p_row);
                chk("hold out_col", out_col, p_col);
                chk("hold out_eol", out_eol, p_eol);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("beat with empty model", out_valid, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_row", out_row, e.row);
                    chk("out_col", out_col, e.col);
                    chk("out_eol", out_eol, e.eol);
                end
                n_beats++;
                if (out_eol) eol_q.push_back(n_beats);
                if (!got_first) begin
                    got_first = 1; first_data = out_data; first_row = out_row; first_col = out_col;
                end
                if (n_fd == 1 && !got_after) begin
                    got_after = 1; after_row = out_row; after_col = out_col;
                end
                if (out_row == 2 && out_col == 624) pix624 = out_data[WW-1 -: 8];
                if (out_row == 9'(OH-1) && out_col == 10'(OW-TW)) exp_fd = 1;
            end
            if (frame_done) begin n_fd++; beats_at_fd = n_beats; end
            p_stall = out_valid && !out_ready;
            p_data = out_data; p_row = out_row; p_col = out_col; p_eol = out_eol;
            if (tile_valid && tile_ready) model_accept(tile_data);
        end
    end

    always @(posedge clk) if (tog) begin #1; out_ready = ~out_ready; end

    task automatic send_tile(input int g);
        int k;
        bit done;
        k = 0; done = 0;
        tile_valid = 1; tile_data = mk_tile(g);
        while (!done && k < 2000) begin
            @(negedge clk); done = tile_ready; k++;
            @(posedge clk); #1;
        end
        tile_valid = 0;
        chk("tile accepted", done, 1);
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k;
        k = 0;
        while (n_beats < n && k < budget) begin @(posedge clk); k++; end
        repeat (20) @(posedge clk);
        #1;
        chk("beat count", n_beats, n);
        chk("model queue drained", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int acc, g, k;
        bit stalled;

        // Reset values
        @(negedge clk);
        chk("rst tile_ready", tile_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_row", out_row, 0);
        chk("rst out_col", out_col, 0);
        chk("rst out_eol", out_eol, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst overrun", overrun, 0);
        @(posedge clk); #1 rst_n = 1;

        // Single band, out_ready held high
        out_ready = 1; clr_stats();
        for (int t = 0; t < TPB; t++) send_tile(t);
        chk("out_valid at accept edge", out_valid, 0);
        @(posedge clk); #1 chk("out_valid after 1 edge", out_valid, 0);
        @(posedge clk); #1 chk("out_valid after 2 edges", out_valid, 1);
        wait_beats(159, 1000);
        chk("first beat data", first_data, 96'h000102030405060708090A0B);
        chk("first beat row", first_row, 0);
        chk("first beat col", first_col, 0);
        chk("row2 col624 pixel0", pix624, 8'h7E);
        chk("eol count", eol_q.size(), 3);
        for (int i = 0; i < eol_q.size() && i < 3; i++) chk("eol beat index", eol_q[i], (i+1)*53);

        // Stall: out_ready low, tile_valid held
        do_reset(); clr_stats(); out_ready = 0;
        acc = 0; g = 0; k = 0; stalled = 0;
        tile_valid = 1; tile_data = mk_tile(0);
        while (!stalled && k < 300) begin
            @(negedge clk); k++;
            if (tile_ready) acc++; else stalled = 1;
            @(posedge clk); #1;
            if (!stalled) begin g++; tile_data = mk_tile(g); end
        end
        chk("tiles accepted before stall", acc, 106);
        @(negedge clk);
        chk("107th tile held", tile_ready, 0);
        chk("overrun after stall", overrun, OVR_EXP);
        @(posedge clk); #1 out_ready = 1;
        for (int t = 106; t < 3*TPB; t++) send_tile(t);
        wait_beats(3*159, 3000);

        // out_ready toggling every cycle
        do_reset(); clr_stats(); out_ready = 0; tog = 1;
        for (int t = 0; t < TPB; t++) send_tile(1000 + t);
        wait_beats(159, 2000);
        tog = 0;
        @(posedge clk); #2 out_ready = 1;

        // Full frame plus the first band of the next frame
        do_reset(); clr_stats();
        for (int t = 0; t < TPB*NB + TPB; t++) send_tile(t);
        wait_beats(25440 + 159, 40000);
        chk("frame_done pulses", n_fd, 1);
        chk("beats at frame_done", beats_at_fd, 25440);
        chk("next frame row", after_row, 0);
        chk("next frame col", after_col, 0);

        // Reset mid-band with a band pending on the output
        do_reset(); clr_stats(); out_ready = 0;
        for (int t = 0; t < TPB + 20; t++) send_tile(t);
        repeat (3) @(posedge clk);
        #1 chk("out_valid before reset", out_valid, 1);
        rst_n = 0;
        #1;
        chk("out_valid in reset", out_valid, 0);
        chk("tile_ready in reset", tile_ready, 1);
        @(posedge clk); #1 rst_n = 1;
        clr_stats(); out_ready = 1;
        for (int t = 0; t < TPB; t++) send_tile(t);
        wait_beats(159, 1000);
        chk("post-reset first row", first_row, 0);
        chk("post-reset first col", first_col, 0);
        chk("post-reset first data", first_data, 96'h000102030405060708090A0B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
